// File: rtl/data_memory_controller_pkg.sv
// Shared encodings and sizing for the byte-serial data memory controller.
// Holds the access size codes, FSM state encoding and the memory geometry.
package data_memory_controller_pkg;

   localparam int MEM_DEPTH = 512;
   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 32;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_ILLEGAL = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

   // Index of the last byte of an access (byte count minus one).
   function automatic logic [1:0] last_index(size_e size);
      case (size)
         SIZE_HALF: last_index = 2'd1;
         SIZE_WORD: last_index = 2'd3;
         default:   last_index = 2'd0;
      endcase
   endfunction

   function automatic logic is_legal(size_e size, logic [ADDR_W-1:0] addr);
      case (size)
         SIZE_BYTE: is_legal = 1'b1;
         SIZE_HALF: is_legal = ~addr[0];
         SIZE_WORD: is_legal = (addr[1:0] == 2'b00);
         default:   is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_controller_ram_512x8.sv
// 512x8 byte storage: synchronous write port, asynchronous read port.
// Contents are never reset.
module ram_512x8
   import data_memory_controller_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);

   logic [7:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_controller.sv
// Byte-serial load/store controller over a 512x8 RAM, big-endian.
// One byte moves per ACCESS cycle; loads are sign/zero extended into DataOut.
module data_memory_controller
   import data_memory_controller_pkg::*;
(
   input  logic              Clk,
   input  logic              Clr,
   input  logic              RAM_Enable,
   input  logic              RAM_RW,
   input  logic              RAM_SE,
   input  logic [1:0]        RAM_Size,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] DataOut,
   output logic              Busy,
   output logic              Done,
   output logic              Misalign
);

   state_e              state;
   logic [1:0]          cnt;
   logic [ADDR_W-1:0]   addr_q;
   logic                rw_q;
   logic                se_q;
   size_e               size_q;
   logic [DATA_W-1:0]   din_q;
   logic [DATA_W-1:0]   asm_q;

   logic [ADDR_W-1:0]   mem_addr;
   logic [7:0]          rd_byte;
   logic [7:0]          wr_byte;
   logic [1:0]          byte_sel;
   logic [DATA_W-1:0]   assembled;
   logic                last;
   logic                mem_we;
   size_e               req_size;

   function automatic logic [DATA_W-1:0] extend(logic [DATA_W-1:0] v, size_e size, logic se);
      case (size)
         SIZE_BYTE: extend = se ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
         SIZE_HALF: extend = se ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
         default:   extend = v;
      endcase
   endfunction

   assign req_size  = size_e'(RAM_Size);
   assign last      = (cnt == last_index(size_q));
   // 9-bit adder wraps modulo 512 by construction.
   assign mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, cnt};
   // Big-endian: counter 0 carries the most significant byte of the access.
   assign byte_sel  = last_index(size_q) - cnt;
   assign wr_byte   = 8'(din_q >> {byte_sel, 3'b000});
   assign assembled = {asm_q[DATA_W-9:0], rd_byte};
   assign mem_we    = (state == ST_ACCESS) && rw_q;

   ram_512x8 u_ram (
      .clk   (Clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (wr_byte),
      .rdata (rd_byte)
   );

   // Operand latch and load assembly: datapath only, no reset.
   always_ff @(posedge Clk) begin
      if (state == ST_IDLE && RAM_Enable) begin
         addr_q <= Address;
         rw_q   <= RAM_RW;
         se_q   <= RAM_SE;
         size_q <= req_size;
         din_q  <= DataIn;
      end
      if (state == ST_ACCESS) asm_q <= assembled;
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state    <= ST_IDLE;
         cnt      <= 2'd0;
         DataOut  <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Misalign <= 1'b0;
      end else begin
         Misalign <= 1'b0;
         case (state)
            ST_IDLE: begin
               Done <= 1'b0;
               if (RAM_Enable) begin
                  if (is_legal(req_size, Address)) begin
                     state <= ST_ACCESS;
                     cnt   <= 2'd0;
                     Busy  <= 1'b1;
                  end else begin
                     Misalign <= 1'b1;
                  end
               end
            end
            ST_ACCESS: begin
               if (last) begin
                  state <= ST_DONE;
                  Done  <= 1'b1;
                  if (!rw_q) DataOut <= extend(assembled, size_q, se_q);
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller with an expected-DataOut scoreboard.
module tb_data_memory_controller;

   logic        Clk = 1'b0;
   logic        Clr = 1'b0;
   logic        RAM_Enable = 1'b0;
   logic        RAM_RW = 1'b0;
   logic        RAM_SE = 1'b0;
   logic [1:0]  RAM_Size = 2'b00;
   logic [8:0]  Address = 9'd0;
   logic [31:0] DataIn = 32'd0;
   logic [31:0] DataOut;
   logic        Busy;
   logic        Done;
   logic        Misalign;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb_q[$];
   logic [31:0] model_dout = 32'd0;

   data_memory_controller dut (
      .Clk        (Clk),
      .Clr        (Clr),
      .RAM_Enable (RAM_Enable),
      .RAM_RW     (RAM_RW),
      .RAM_SE     (RAM_SE),
      .RAM_Size   (RAM_Size),
      .Address    (Address),
      .DataIn     (DataIn),
      .DataOut    (DataOut),
      .Busy       (Busy),
      .Done       (Done),
      .Misalign   (Misalign)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request; n = byte count; poke fires an extra enable while busy;
   // clr_at > 0 asserts Clr after that many edges counted from the accepting edge.
   task automatic req(input string tag, input logic rw, input logic se, input logic [1:0] size,
                      input logic [8:0] addr, input logic [31:0] din, input logic [31:0] exp_out,
                      input int n, input bit poke, input int clr_at);
      int lat;
      bit aborted;
      logic [31:0] exp_pop;
      sb_q.push_back(rw ? model_dout : exp_out);
      @(negedge Clk);
      RAM_RW = rw; RAM_SE = se; RAM_Size = size; Address = addr; DataIn = din;
      RAM_Enable = 1'b1;
      lat = 0;
      aborted = 1'b0;
      do begin
         @(posedge Clk); #1;
         lat++;
         if (lat == 1) begin
            RAM_Enable = 1'b0;
            check({tag, " busy_after_accept"}, {31'd0, Busy}, 32'd1);
            DataIn  = ~din;
            Address = addr ^ 9'h155;
            RAM_SE  = ~se;
         end
         if (poke && lat == 2) begin
            RAM_Enable = 1'b1; RAM_RW = 1'b1; RAM_Size = 2'b10;
            Address = 9'h000; DataIn = 32'h5A5A5A5A;
         end
         if (poke && lat == 3) RAM_Enable = 1'b0;
         if (clr_at == lat) begin
            Clr = 1'b0;
            #1;
            check({tag, " rst_dataout"}, DataOut, 32'd0);
            check({tag, " rst_flags"}, {29'd0, Busy, Done, Misalign}, 32'd0);
            model_dout = 32'd0;
            void'(sb_q.pop_front());
            aborted = 1'b1;
            @(negedge Clk);
            Clr = 1'b1;
         end
      end while (!aborted && !Done && lat < 12);
      if (!aborted) begin
         check({tag, " latency"}, lat, n + 1);
         if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
         end else begin
            exp_pop = sb_q.pop_front();
            check({tag, " dataout"}, DataOut, exp_pop);
            if (!rw) model_dout = exp_pop;
         end
         @(posedge Clk); #1;
         check({tag, " idle_after_done"}, {30'd0, Busy, Done}, 32'd0);
      end
   endtask

   task automatic mis(input string tag, input logic [1:0] size, input logic [8:0] addr);
      @(negedge Clk);
      RAM_RW = 1'b0; RAM_SE = 1'b1; RAM_Size = size; Address = addr; DataIn = 32'h0;
      RAM_Enable = 1'b1;
      @(posedge Clk); #1;
      RAM_Enable = 1'b0;
      check({tag, " misalign_pulse"}, {30'd0, Misalign, Busy}, 32'd2);
      @(posedge Clk); #1;
      check({tag, " misalign_clear"}, {30'd0, Misalign, Busy}, 32'd0);
      check({tag, " dataout_kept"}, DataOut, model_dout);
   endtask

   initial begin
      #1;
      check("reset_dataout", DataOut, 32'd0);
      check("reset_flags", {29'd0, Busy, Done, Misalign}, 32'd0);
      @(negedge Clk);
      Clr = 1'b1;

      req("st_word_010", 1'b1, 1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 32'h0, 4, 1'b0, 0);
      req("ld_word_010", 1'b0, 1'b1, 2'b10, 9'h010, 32'h0, 32'hDEADBEEF, 4, 1'b0, 0);
      req("ld_byte_011", 1'b0, 1'b0, 2'b00, 9'h011, 32'h0, 32'h000000AD, 1, 1'b0, 0);
      req("ld_byte_013s", 1'b0, 1'b1, 2'b00, 9'h013, 32'h0, 32'hFFFFFFEF, 1, 1'b0, 0);

      req("st_byte_021", 1'b1, 1'b0, 2'b00, 9'h021, 32'h12345680, 32'h0, 1, 1'b0, 0);
      req("ld_byte_021s", 1'b0, 1'b1, 2'b00, 9'h021, 32'h0, 32'hFFFFFF80, 1, 1'b0, 0);
      req("ld_byte_021u", 1'b0, 1'b0, 2'b00, 9'h021, 32'h0, 32'h00000080, 1, 1'b0, 0);

      req("st_half_040", 1'b1, 1'b0, 2'b01, 9'h040, 32'hFFFF8001, 32'h0, 2, 1'b0, 0);
      req("ld_half_040s", 1'b0, 1'b1, 2'b01, 9'h040, 32'h0, 32'hFFFF8001, 2, 1'b0, 0);
      req("ld_half_040u", 1'b0, 1'b0, 2'b01, 9'h040, 32'h0, 32'h00008001, 2, 1'b0, 0);

      mis("mis_half_041", 2'b01, 9'h041);
      mis("mis_size11", 2'b11, 9'h000);
      mis("mis_word_012", 2'b10, 9'h012);
      req("ld_half_040_after_mis", 1'b0, 1'b1, 2'b01, 9'h040, 32'h0, 32'hFFFF8001, 2, 1'b0, 0);

      req("st_word_000", 1'b1, 1'b0, 2'b10, 9'h000, 32'h01020304, 32'h0, 4, 1'b0, 0);
      req("st_word_1fc_poke", 1'b1, 1'b0, 2'b10, 9'h1FC, 32'hCAFEF00D, 32'h0, 4, 1'b1, 0);
      req("ld_word_1fc", 1'b0, 1'b0, 2'b10, 9'h1FC, 32'h0, 32'hCAFEF00D, 4, 1'b0, 0);
      req("ld_byte_1ff", 1'b0, 1'b0, 2'b00, 9'h1FF, 32'h0, 32'h0000000D, 1, 1'b0, 0);
      req("ld_word_000", 1'b0, 1'b0, 2'b10, 9'h000, 32'h0, 32'h01020304, 4, 1'b0, 0);

      req("st_word_080", 1'b1, 1'b0, 2'b10, 9'h080, 32'hA5A5A5A5, 32'h0, 4, 1'b0, 0);
      req("ld_word_010_again", 1'b0, 1'b0, 2'b10, 9'h010, 32'h0, 32'hDEADBEEF, 4, 1'b0, 0);
      req("st_word_080_clr", 1'b1, 1'b0, 2'b10, 9'h080, 32'h11223344, 32'h0, 4, 1'b0, 3);
      req("ld_word_080", 1'b0, 1'b0, 2'b10, 9'h080, 32'h0, 32'h1122A5A5, 4, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
